crc_frame_checker: RTL and testbench
====================================

# crc_frame_checker

Receive-side frame checker that consumes a byte stream from the serial/bus receiver and validates CRC-16/CCITT. Each frame's trailing two bytes are the CRC. The block strips them using a 2-byte holdoff buffer and forwards only payload bytes downstream. At each frame end it reports pass/fail status and payload length, so the packet parser can commit or discard the buffered payload.

## Interface
- MAX_PAYLOAD, 1024: largest accepted payload byte count; payload bytes beyond this are suppressed and the frame fails.
- LEN_W, 16: width of frame_len; must hold MAX_PAYLOAD.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_d  in  8  received byte.
- in_dv  in  1  in_d valid this cycle; no backpressure, every in_dv byte is accepted.
- in_last  in  1  qualifies in_dv; the byte is the final byte of the frame (CRC low byte).
- out_d  out  8  payload byte.
- out_dv  out  1  out_d valid (single-cycle per byte).
- out_last  out  1  with out_dv: last payload byte of a non-overflowed frame.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_good  out  1  valid with frame_done; 1 = CRC residue zero, not runt, not overflow.
- frame_runt  out  1  valid with frame_done; frame had fewer than 3 bytes.
- frame_ovf  out  1  valid with frame_done; payload exceeded MAX_PAYLOAD.
- frame_len  out  LEN_W  valid with frame_done; payload bytes emitted (total bytes minus 2, saturated at MAX_PAYLOAD, 0 for runts).
- bad_cnt  out  16  count of frame_done pulses with frame_good=0; saturates at 16'hFFFF.

## Operation
- CRC algorithm: CRC-16/CCITT-FALSE.
  - Polynomial 0x1021, MSB-first, no reflection, no final XOR.
  - Byte update XORs data into CRC bits [15:8].
  - Sender appends CRC high byte then low byte.
- Check method: the CRC is run over all bytes, CRC bytes included. The frame passes iff the final register value is 16'h0000.
- CRC register is seeded with 16'hFFFF on the first byte of each frame: update uses FFFF instead of the held value. No idle cycle is needed between frames.
- Holdoff buffer: h0 holds the newest byte, h1 the older byte; held count is 0..2.
- States:
  - EMPTY: held count 0. A byte loads h0 and goes to ONE; if in_last, end frame as runt instead.
  - ONE: held count 1. A byte shifts h0→h1, loads h0, goes to TWO; if in_last, end frame as runt.
  - TWO: held count 2. Each accepted byte releases h1 as a payload byte, then shifts.
  - An in_last byte in TWO releases h1 with out_last, ends the frame, and returns to EMPTY.
- Payload counter increments per released byte.
- Overflow: when a release would make the counter exceed MAX_PAYLOAD, set the ovf flag for the rest of the frame. Suppress out_dv for that byte and all later bytes; the counter holds at MAX_PAYLOAD.
- out_last is never asserted in an overflowed frame. Downstream relies on frame_done/frame_good.
- A runt frame emits no payload and reports frame_len=0, frame_runt=1, frame_good=0.
- in_dv low mid-frame: everything holds; gaps of any length are allowed.
- Frame end:
  - Pulse frame_done with the status outputs.
  - Clear ovf, runt and the counter.
  - Increment bad_cnt if the frame failed.
- rst_n low: all state returns to EMPTY, counters and flags clear, bad_cnt=0.
  - A partial frame is discarded with no frame_done.
  - The next byte after reset starts a new frame.

## Timing
- Reset values: out_d=0, out_dv=0, out_last=0, frame_done=0, frame_good=0, frame_runt=0, frame_ovf=0, frame_len=0, bad_cnt=0.
- All outputs are registered.
- Payload byte k appears on out_d/out_dv the cycle after byte k+2 of the frame is accepted.
- frame_done and status outputs appear the cycle after the in_last byte is accepted, coincident with out_last.
- bad_cnt updates in the same cycle as frame_done.
- Status outputs hold their value until the next frame_done; only frame_done, out_dv and out_last are pulses.
- Back-to-back frames: the first byte of frame N+1 may arrive the cycle after in_last of frame N. The frame N frame_done and frame N+1 byte intake do not interfere.
- Sustained throughput: one byte per cycle.

## Test plan
- ASCII "123456789" followed by 0x29, 0xB1, back-to-back: out_d sequence 0x31..0x39, with out_last on 0x39. frame_done then gives good=1, len=9, bad_cnt=0.
- Same frame with last byte 0xB0: identical payload output; frame_good=0, runt=0, ovf=0, bad_cnt=1.
- Frames of 1 byte and 2 bytes (0x12, 0x34 with in_last): no out_dv. Each gives frame_done with runt=1, good=0, len=0; bad_cnt increments by 2.
- MAX_PAYLOAD=4, with a 6-byte payload plus its valid CRC: exactly 4 out_dv, no out_last. frame_done gives ovf=1, good=0, len=4.
- Good frame, then random in_dv gaps within a second good frame, then a third frame starting the cycle after in_last: all three report good=1 with correct lengths.
- rst_n pulsed low for 1 cycle mid-frame after 5 bytes: no frame_done for the partial frame, bad_cnt=0. The following "123456789"+0x29,0xB1 frame passes.

Source files
------------

// File: rtl/crc_frame_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | crc_frame_checker: strips the trailing CRC-16/CCITT-FALSE from each       |
// | received frame, forwards payload and reports per-frame status. Rev 1.0    |
// +--------------------------------------------------------------------------+
module crc_frame_checker #(
    parameter int MAX_PAYLOAD = 1024,
    parameter int LEN_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_d,
    input  logic             in_dv,
    input  logic             in_last,
    output logic [7:0]       out_d,
    output logic             out_dv,
    output logic             out_last,
    output logic             frame_done,
    output logic             frame_good,
    output logic             frame_runt,
    output logic             frame_ovf,
    output logic [LEN_W-1:0] frame_len,
    output logic [15:0]      bad_cnt
);

    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_PAYLOAD);
    localparam logic [LEN_W-1:0] c_one     = LEN_W'(1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    logic [7:0]       r_h0;
    logic [7:0]       r_h1;
    logic [15:0]      r_crc;
    logic [LEN_W-1:0] r_cnt;
    logic             r_ovf;

    logic [15:0]      w_crc_seed;
    logic [15:0]      w_crc_next;
    logic             w_release_ok;
    logic             w_ovf_final;
    logic             w_good;
    logic [LEN_W-1:0] w_cnt_next;
    logic [15:0]      w_bad_inc;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // The first byte of a frame always arrives in EMPTY, so that is where the seed applies.
    assign w_crc_seed   = (r_state == S_EMPTY) ? 16'hFFFF : r_crc;
    assign w_crc_next   = crc16_byte(w_crc_seed, in_d);
    assign w_release_ok = !r_ovf && (r_cnt < c_max_len);
    assign w_ovf_final  = r_ovf || !w_release_ok;
    assign w_good       = (w_crc_next == 16'h0000) && !w_ovf_final;
    assign w_cnt_next   = w_release_ok ? (r_cnt + c_one) : r_cnt;
    assign w_bad_inc    = (bad_cnt == 16'hFFFF) ? bad_cnt : (bad_cnt + 16'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_h0       <= 8'h00;
            r_h1       <= 8'h00;
            r_crc      <= 16'hFFFF;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            out_d      <= 8'h00;
            out_dv     <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            frame_good <= 1'b0;
            frame_runt <= 1'b0;
            frame_ovf  <= 1'b0;
            frame_len  <= '0;
            bad_cnt    <= 16'h0000;
        end else begin
            out_dv     <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            if (in_dv) begin
                r_crc <= w_crc_next;
                case (r_state)
                    S_EMPTY, S_ONE: begin
                        if (in_last) begin
                            frame_done <= 1'b1;
                            frame_good <= 1'b0;
                            frame_runt <= 1'b1;
                            frame_ovf  <= 1'b0;
                            frame_len  <= '0;
                            bad_cnt    <= w_bad_inc;
                            r_cnt      <= '0;
                            r_ovf      <= 1'b0;
                            r_state    <= S_EMPTY;
                        end else begin
                            r_h1    <= r_h0;
                            r_h0    <= in_d;
                            r_state <= (r_state == S_EMPTY) ? S_ONE : S_TWO;
                        end
                    end
                    S_TWO: begin
                        r_h1 <= r_h0;
                        r_h0 <= in_d;
                        // Once overflowed, no later byte of this frame is forwarded.
                        if (w_release_ok) begin
                            out_d    <= r_h1;
                            out_dv   <= 1'b1;
                            out_last <= in_last;
                        end
                        if (in_last) begin
                            frame_done <= 1'b1;
                            frame_good <= w_good;
                            frame_runt <= 1'b0;
                            frame_ovf  <= w_ovf_final;
                            frame_len  <= w_cnt_next;
                            if (!w_good) begin
                                bad_cnt <= w_bad_inc;
                            end
                            r_cnt   <= '0;
                            r_ovf   <= 1'b0;
                            r_state <= S_EMPTY;
                        end else begin
                            r_cnt <= w_cnt_next;
                            r_ovf <= w_ovf_final;
                        end
                    end
                    default: r_state <= S_EMPTY;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_frame_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_crc_frame_checker: scoreboard bench for crc_frame_checker, one default |
// | instance and one with MAX_PAYLOAD=4. Rev 1.0                              |
// +--------------------------------------------------------------------------+
module tb_crc_frame_checker;

    typedef struct packed {
        logic        good;
        logic        runt;
        logic        ovf;
        logic [15:0] len;
        logic [15:0] bad;
    } stat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_d = 8'h00, s_in_d = 8'h00;
    logic        in_dv = 1'b0, in_last = 1'b0, s_in_dv = 1'b0, s_in_last = 1'b0;
    logic [7:0]  out_d, s_out_d;
    logic        out_dv, out_last, frame_done, frame_good, frame_runt, frame_ovf;
    logic        s_out_dv, s_out_last, s_frame_done, s_frame_good, s_frame_runt, s_frame_ovf;
    logic [15:0] frame_len, bad_cnt, s_frame_len, s_bad_cnt;

    logic [8:0]  bq0[$], bq1[$];
    stat_t       sq0[$], sq1[$];
    logic [7:0]  frm[$];
    int          exp_bad[2];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    crc_frame_checker #(.MAX_PAYLOAD(1024), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_d(in_d), .in_dv(in_dv), .in_last(in_last),
        .out_d(out_d), .out_dv(out_dv), .out_last(out_last), .frame_done(frame_done),
        .frame_good(frame_good), .frame_runt(frame_runt), .frame_ovf(frame_ovf),
        .frame_len(frame_len), .bad_cnt(bad_cnt)
    );

    crc_frame_checker #(.MAX_PAYLOAD(4), .LEN_W(16)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_d(s_in_d), .in_dv(s_in_dv), .in_last(s_in_last),
        .out_d(s_out_d), .out_dv(s_out_dv), .out_last(s_out_last), .frame_done(s_frame_done),
        .frame_good(s_frame_good), .frame_runt(s_frame_runt), .frame_ovf(s_frame_ovf),
        .frame_len(s_frame_len), .bad_cnt(s_bad_cnt)
    );

    // Bit-serial reference CRC-16/CCITT-FALSE.
    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic fb;
        for (int b = 7; b >= 0; b--) begin
            fb = c[15] ^ d[b];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic mon(input int w, input logic dv, input logic [7:0] d, input logic last,
                       input logic done, input stat_t obs);
        logic [8:0] eb;
        stat_t      es;
        int         bsz, ssz;
        bsz = (w == 0) ? bq0.size() : bq1.size();
        ssz = (w == 0) ? sq0.size() : sq1.size();
        if (last) begin
            vectors++;
            assert (dv === 1'b1) else begin
                miscompares++;
                $error("FAIL last_without_dv[%0d] out_dv=%b expected 1", w, dv);
            end
        end
        if (dv) begin
            vectors++;
            assert (bsz > 0) else begin
                miscompares++;
                $error("FAIL unexpected_byte[%0d] got last/d=%h expected none", w, {last, d});
            end
            if (bsz > 0) begin
                if (w == 0) eb = bq0.pop_front(); else eb = bq1.pop_front();
                vectors++;
                assert ({last, d} === eb) else begin
                    miscompares++;
                    $error("FAIL byte[%0d] got last/d=%h expected %h", w, {last, d}, eb);
                end
            end
        end
        if (done) begin
            vectors++;
            assert (ssz > 0) else begin
                miscompares++;
                $error("FAIL unexpected_frame_done[%0d] got %h expected none", w, obs);
            end
            if (ssz > 0) begin
                if (w == 0) es = sq0.pop_front(); else es = sq1.pop_front();
                vectors++;
                assert (obs === es) else begin
                    miscompares++;
                    $error("FAIL status[%0d] good/runt/ovf/len/bad got %b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d",
                           w, obs.good, obs.runt, obs.ovf, obs.len, obs.bad,
                           es.good, es.runt, es.ovf, es.len, es.bad);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, out_dv, out_d, out_last, frame_done,
            {frame_good, frame_runt, frame_ovf, frame_len, bad_cnt});
        mon(1, s_out_dv, s_out_d, s_out_last, s_frame_done,
            {s_frame_good, s_frame_runt, s_frame_ovf, s_frame_len, s_bad_cnt});
    end

    task automatic drive_byte(input int w, input logic [7:0] d, input logic last);
        if (w == 0) begin in_d = d; in_dv = 1'b1; in_last = last; end
        else begin s_in_d = d; s_in_dv = 1'b1; s_in_last = last; end
        @(posedge clk); #1;
    endtask

    task automatic go_idle(input int w, input int cycles);
        if (w == 0) begin in_dv = 1'b0; in_last = 1'b0; end
        else begin s_in_dv = 1'b0; s_in_last = 1'b0; end
        repeat (cycles) begin @(posedge clk); #1; end
    endtask

    task automatic build(input int npl, input bit rnd, input bit corrupt);
        logic [15:0] c;
        frm.delete();
        c = 16'hFFFF;
        for (int i = 0; i < npl; i++) begin
            frm.push_back(rnd ? 8'($urandom) : 8'(8'hA0 + i));
            c = crc_upd(c, frm[i]);
        end
        frm.push_back(c[15:8]);
        frm.push_back(c[7:0] ^ {7'd0, corrupt});
    endtask

    task automatic check_frame(input logic [7:0] last_byte);
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'(8'h31 + i));
        frm.push_back(8'h29);
        frm.push_back(last_byte);
    endtask

    // Pushes the expected outcome of frm, then sends it; in_dv is left low without a clock edge
    // so a following frame still starts back-to-back.
    task automatic run_frame(input int w, input int max_pl, input bit gaps);
        int          n, pl, emit;
        logic [15:0] r;
        bit          runt, ovf, good;
        stat_t       s;
        n = frm.size();
        r = 16'hFFFF;
        foreach (frm[i]) r = crc_upd(r, frm[i]);
        runt = (n < 3);
        pl   = runt ? 0 : n - 2;
        ovf  = (pl > max_pl);
        emit = ovf ? max_pl : pl;
        good = !runt && !ovf && (r == 16'h0000);
        for (int k = 0; k < emit; k++) begin
            if (w == 0) bq0.push_back({(k == pl - 1) && !ovf, frm[k]});
            else        bq1.push_back({(k == pl - 1) && !ovf, frm[k]});
        end
        if (!good && exp_bad[w] < 65535) exp_bad[w]++;
        s.good = good; s.runt = runt; s.ovf = ovf;
        s.len = 16'(emit); s.bad = 16'(exp_bad[w]);
        if (w == 0) sq0.push_back(s); else sq1.push_back(s);
        for (int i = 0; i < n; i++) begin
            drive_byte(w, frm[i], i == n - 1);
            if (gaps && i != n - 1) go_idle(w, $urandom_range(0, 3));
        end
        if (w == 0) begin in_dv = 1'b0; in_last = 1'b0; end
        else begin s_in_dv = 1'b0; s_in_last = 1'b0; end
    endtask

    initial begin
        exp_bad[0] = 0;
        exp_bad[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        assert ({out_d, out_dv, out_last, frame_done, frame_good, frame_runt, frame_ovf, frame_len} === '0)
        else begin
            miscompares++;
            $error("FAIL reset_outputs got %h expected 0",
                   {out_d, out_dv, out_last, frame_done, frame_good, frame_runt, frame_ovf, frame_len});
        end
        vectors++;
        assert (bad_cnt === 16'h0000) else begin
            miscompares++;
            $error("FAIL reset_bad_cnt got %h expected 0000", bad_cnt);
        end
        vectors++;
        assert ({s_out_dv, s_frame_done, s_bad_cnt} === '0) else begin
            miscompares++;
            $error("FAIL reset_small got %h expected 0", {s_out_dv, s_frame_done, s_bad_cnt});
        end
        rst_n = 1'b1;
        go_idle(0, 2);

        // Good check frame, then the corrupted copy back-to-back.
        check_frame(8'hB1); run_frame(0, 1024, 1'b0);
        check_frame(8'hB0); run_frame(0, 1024, 1'b0);
        go_idle(0, 3);

        // Runts: one byte, then two bytes.
        frm.delete(); frm.push_back(8'h12); run_frame(0, 1024, 1'b0);
        go_idle(0, 2);
        frm.delete(); frm.push_back(8'h12); frm.push_back(8'h34); run_frame(0, 1024, 1'b0);
        go_idle(0, 3);

        // Good frame, gapped good frame, then a back-to-back good frame.
        check_frame(8'hB1); run_frame(0, 1024, 1'b0);
        go_idle(0, 2);
        build(20, 1'b1, 1'b0); run_frame(0, 1024, 1'b1);
        build(7, 1'b1, 1'b0);  run_frame(0, 1024, 1'b0);
        go_idle(0, 3);

        // Overflow on the MAX_PAYLOAD=4 instance.
        build(6, 1'b0, 1'b0); run_frame(1, 4, 1'b0);
        go_idle(1, 3);

        // Reset after 5 bytes: three payload bytes already released, no frame_done.
        check_frame(8'hB1);
        for (int k = 0; k < 3; k++) bq0.push_back({1'b0, frm[k]});
        for (int i = 0; i < 5; i++) drive_byte(0, frm[i], 1'b0);
        in_dv = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_bad[0] = 0;
        exp_bad[1] = 0;
        vectors++;
        assert (bad_cnt === 16'h0000) else begin
            miscompares++;
            $error("FAIL bad_cnt_after_reset got %h expected 0000", bad_cnt);
        end
        check_frame(8'hB1); run_frame(0, 1024, 1'b0);
        go_idle(0, 6);

        vectors++;
        assert ((bq0.size() + bq1.size() + sq0.size() + sq1.size()) === 0) else begin
            miscompares++;
            $error("FAIL drain outstanding got %0d expected 0",
                   bq0.size() + bq1.size() + sq0.size() + sq1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
